reg_logic_pipe: RTL

- Parametrised, pipelined successor to the single-bit registered AND cells.
- Applies a selectable bitwise operation (AND/OR/XOR/NAND) to two WIDTH-bit operands.
- Carries the result through STAGES registered stages under a valid/ready handshake with full backpressure.
- Sits between operand producers and downstream consumers in the pd-series datapath experiments.

---
 rtl/logic_pipe_pkg.sv | 31 +++
 rtl/logic_pipe_stage.sv | 43 ++++
 rtl/reg_logic_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/logic_pipe_pkg.sv
// Shared types and the bitwise operation helper for reg_logic_pipe.
// apply_op works on MAX_W bits; callers zero-extend operands and keep the low WIDTH bits.
package logic_pipe_pkg;

  localparam int OP_W  = 2;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  function automatic logic [MAX_W-1:0] apply_op(
    input op_e              op,
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] y
  );
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      default: r = {MAX_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot of reg_logic_pipe: a valid bit plus DW data bits, async active-high reset.
// Data is only captured for valid loads so an emptied slot keeps its last contents.
module logic_pipe_stage #(
  parameter int DW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Slot valid follows upstream on every load; bubbles simply overwrite it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= up_valid;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Slot payload, captured only when a real item arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= {DW{1'b0}};
    end else if (load && up_valid) begin
      r_data <= up_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/reg_logic_pipe.sv
// Bitwise AND/OR/XOR/NAND unit followed by STAGES valid/ready pipeline slots.
// Optional statistics ports are enabled with the REG_LOGIC_PIPE_STATS_EN macro.
module reg_logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [1:0]       out_op
`ifdef REG_LOGIC_PIPE_STATS_EN
  ,
  output logic [15:0]      out_count,
  output logic             out_zero
`endif
);

  localparam int DW = WIDTH + OP_W;

  logic [MAX_W-1:0] w_x_ext;
  logic [MAX_W-1:0] w_y_ext;
  logic [MAX_W-1:0] w_res_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_unused_res;
  logic [DW-1:0]    w_in_data;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_adv;
  logic [DW-1:0]    w_data [STAGES];

  // Zero-extend operands to the helper's native width.
  always_comb begin
    w_x_ext = {MAX_W{1'b0}};
    w_y_ext = {MAX_W{1'b0}};
    w_x_ext[WIDTH-1:0] = in_x;
    w_y_ext[WIDTH-1:0] = in_y;
  end

  assign w_res_ext    = apply_op(op_e'(in_op), w_x_ext, w_y_ext);
  assign w_res        = w_res_ext[WIDTH-1:0];
  assign w_unused_res = ^w_res_ext;
  assign w_in_data    = {in_op, w_res};

  // A slot may advance if it or any slot downstream of it is empty, or the consumer takes the head.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign w_adv[g] = out_ready | ~(&w_valid[STAGES-1:g]);
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          w_up_valid;
    logic [DW-1:0] w_up_data;

    if (g == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = w_in_data;
    end else begin : g_body
      assign w_up_valid = w_valid[g-1];
      assign w_up_data  = w_data[g-1];
    end

    logic_pipe_stage #(
      .DW (DW)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .load     (w_adv[g]),
      .up_valid (w_up_valid),
      .up_data  (w_up_data),
      .valid    (w_valid[g]),
      .data     (w_data[g])
    );
  end

  assign in_ready  = w_adv[0] & ~reset;
  assign out_valid = w_valid[STAGES-1];
  assign out_z     = w_data[STAGES-1][WIDTH-1:0];
  assign out_op    = w_data[STAGES-1][DW-1:WIDTH];

`ifdef REG_LOGIC_PIPE_STATS_EN
  logic [15:0] r_out_count;

  // Output transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      r_out_count <= r_out_count + 16'd1;
    end else begin
      r_out_count <= r_out_count;
    end
  end

  assign out_count = r_out_count;
  assign out_zero  = (out_z == {WIDTH{1'b0}}) && out_valid;
`endif

endmodule
